// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic pipeline register placed between two adjacent LC-3b pipeline
// stages. It replaces an always-load stage register with a valid/ready
// handshake. It also supports:
//   - an optional second (skid) slot,
//   - a synchronous flush for branch/trap redirects,
//   - NOP insertion whenever no valid bundle is held,
//   - a saturating stall counter for performance measurement.
//
// Parameters:
//   WIDTH  width of the packed stage bundle
//   NOP    bundle value presented on out_data while out_valid is 0
//   SKID   1 = two slots with in_ready taken from registered state only,
//          0 = single slot with combinational in_ready
//   CNT_W  width of the stall counter
//
// Ports:
//   clk        stage clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream holds a valid bundle
//   in_ready   this stage accepts a bundle this cycle
//   in_data    upstream bundle
//   flush      synchronous kill of every held bundle
//   out_valid  out_data holds a valid bundle
//   out_ready  downstream accepts this cycle
//   out_data   bundle to downstream, NOP when not valid
//   occupancy  number of held bundles, 0..2
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] NOP   = '0,
   parameter bit               SKID  = 1'b1,
   parameter int               CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   // The state encoding is the number of held bundles. This lets occupancy
   // be driven directly from the state register.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept;
   logic             issue;

   // The main slot always holds the oldest bundle, so it is the only slot
   // that is ever presented downstream.
   //
   // With the skid slot enabled, in_ready depends only on registered state.
   // This breaks the ready chain between stages.
   //
   // Without the skid slot, the single slot may refill on the same edge it
   // drains. In that mode TWO is never reached: an accept while ONE needs
   // out_ready, and out_ready there also implies an issue.
   assign out_valid = (state_q != EMPTY);
   assign in_ready  = SKID ? (state_q != TWO) : (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign issue     = out_valid && out_ready;
   assign out_data  = out_valid ? main_q : NOP;
   assign occupancy = state_q;

   // Next-state and slot-update logic.
   //
   // Flush wins over everything: an accept on the flushing edge is dropped.
   // An issue on that same edge has already been seen by downstream.
   //
   // In ONE with both handshakes, the outgoing bundle is simply overwritten
   // in the main slot. When TWO drains, the skid bundle moves forward so
   // that arrival order is kept.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (accept && issue) begin
                  main_d = in_data;
               end else if (accept) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end else if (issue) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (issue) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // State register. The asynchronous reset empties the stage immediately,
   // so out_valid drops without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Bundle storage. The slot contents do not matter while empty, because
   // out_data is forced to NOP. They are still reset so that simulation
   // never shows X on the slots.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= NOP;
         skid_q <= NOP;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   // Stall counter.
   //
   // It counts edges where downstream refuses a valid bundle. An edge that
   // is being flushed is not a real stall, so it is not counted.
   //
   // The counter pins at its maximum value instead of wrapping. Only reset
   // clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Drives two instances from the same stimulus:
//   - u_skid:   SKID=1, CNT_W=4,  NOP=0
//   - u_noskid: SKID=0, CNT_W=16, NOP=F00D
//
// Both instances are compared against queue-based reference models. Each
// model treats the stage as a bounded FIFO:
//   - the head of the queue is what is presented downstream,
//   - a flush empties the queue,
//   - stalls are counted with saturation.
//
// Directed constant checks cover the headline scenarios.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

   localparam logic [15:0] NOP_A = 16'h0000;
   localparam logic [15:0] NOP_B = 16'hF00D;
   localparam int          MAX_A = 15;
   localparam int          MAX_B = 65535;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        flush;
   logic        out_ready;

   logic        a_in_ready, a_out_valid;
   logic [15:0] a_out_data;
   logic [1:0]  a_occ;
   logic [3:0]  a_stall;

   logic        b_in_ready, b_out_valid;
   logic [15:0] b_out_data;
   logic [1:0]  b_occ;
   logic [15:0] b_stall;

   logic [15:0] qa[$];
   logic [15:0] qb[$];
   int          stall_a;
   int          stall_b;
   int          total;
   int          bad;

   pipe_stage_elastic #(.WIDTH(16), .NOP(NOP_A), .SKID(1'b1), .CNT_W(4)) u_skid (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .flush(flush),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .occupancy(a_occ), .stall_cnt(a_stall)
   );

   pipe_stage_elastic #(.WIDTH(16), .NOP(NOP_B), .SKID(1'b0), .CNT_W(16)) u_noskid (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .occupancy(b_occ), .stall_cnt(b_stall)
   );

   // Free-running stage clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares every output of both instances against the FIFO models.
   task automatic checkAll();
      checkOutput("a.out_valid", a_out_valid, qa.size() > 0);
      checkOutput("a.out_data", a_out_data, (qa.size() > 0) ? qa[0] : NOP_A);
      checkOutput("a.occupancy", a_occ, qa.size());
      checkOutput("a.in_ready", a_in_ready, qa.size() < 2);
      checkOutput("a.stall_cnt", a_stall, stall_a);
      checkOutput("b.out_valid", b_out_valid, qb.size() > 0);
      checkOutput("b.out_data", b_out_data, (qb.size() > 0) ? qb[0] : NOP_B);
      checkOutput("b.occupancy", b_occ, qb.size());
      checkOutput("b.in_ready", b_in_ready, (qb.size() == 0) || out_ready);
      checkOutput("b.stall_cnt", b_stall, stall_b);
   endtask

   // Advances both models by one edge, using the inputs currently applied.
   task automatic stepModels();
      bit acc_a, iss_a, acc_b, iss_b;
      acc_a = in_valid && (qa.size() < 2);
      iss_a = (qa.size() > 0) && out_ready;
      acc_b = in_valid && ((qb.size() == 0) || out_ready);
      iss_b = (qb.size() > 0) && out_ready;
      if (flush) begin
         qa.delete();
         qb.delete();
      end else begin
         if ((qa.size() > 0) && !out_ready && (stall_a < MAX_A)) stall_a++;
         if ((qb.size() > 0) && !out_ready && (stall_b < MAX_B)) stall_b++;
         if (iss_a) void'(qa.pop_front());
         if (acc_a) qa.push_back(in_data);
         if (iss_b) void'(qb.pop_front());
         if (acc_b) qb.push_back(in_data);
      end
   endtask

   // Applies one cycle of inputs at the falling edge and checks the
   // pre-edge outputs. It then lets the rising edge happen and returns
   // 1 time unit after that edge.
   task automatic applyStimulus(input logic iv, input logic [15:0] id, input logic orr, input logic fl);
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = orr;
      flush     = fl;
      #1;
      checkAll();
      stepModels();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      stall_a   = 0;
      stall_b   = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // Reset state.
      #2;
      checkAll();
      checkOutput("rst.a_in_ready", a_in_ready, 1);
      checkOutput("rst.a_out_data", a_out_data, NOP_A);
      checkOutput("rst.b_out_data", b_out_data, NOP_B);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming at full rate with downstream always ready.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 16'h1001 + 16'(i), 1'b1, 1'b0);
         checkOutput("stream.a_data", a_out_data, 16'h1001 + 16'(i));
         checkOutput("stream.b_data", b_out_data, 16'h1001 + 16'(i));
         checkOutput("stream.a_in_ready", a_in_ready, 1);
      end
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("stream.drained", a_out_valid, 0);
      checkOutput("stream.stall", a_stall, 0);

      // Back-pressure fills both slots of the skid instance.
      applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
      checkOutput("bp.a_occ", a_occ, 2);
      checkOutput("bp.a_in_ready", a_in_ready, 0);
      checkOutput("bp.a_data", a_out_data, 16'hAAAA);
      checkOutput("bp.b_in_ready", b_in_ready, 0);
      checkOutput("bp.b_data", b_out_data, 16'hAAAA);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("bp.a_stall", a_stall, 5);
      checkOutput("bp.a_hold", a_out_data, 16'hAAAA);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("bp.second", a_out_data, 16'hBBBB);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("bp.empty_valid", a_out_valid, 0);
      checkOutput("bp.empty_data", a_out_data, NOP_A);

      // Flush with a simultaneous accept: nothing survives.
      applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h3333, 1'b0, 1'b1);
      checkOutput("flush.a_valid", a_out_valid, 0);
      checkOutput("flush.a_occ", a_occ, 0);
      checkOutput("flush.a_in_ready", a_in_ready, 1);
      checkOutput("flush.b_valid", b_out_valid, 0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("flush.no3333", a_out_valid, 0);

      // Asynchronous reset with both slots full.
      applyStimulus(1'b1, 16'h4444, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
      checkOutput("arst.pre_occ", a_occ, 2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst.a_valid", a_out_valid, 0);
      checkOutput("arst.a_data", a_out_data, NOP_A);
      checkOutput("arst.a_in_ready", a_in_ready, 1);
      checkOutput("arst.a_occ", a_occ, 0);
      checkOutput("arst.a_stall", a_stall, 0);
      checkOutput("arst.b_valid", b_out_valid, 0);
      checkOutput("arst.b_data", b_out_data, NOP_B);
      qa.delete();
      qb.delete();
      stall_a  = 0;
      stall_b  = 0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Saturation of the 4-bit counter; the 16-bit counter keeps counting.
      applyStimulus(1'b1, 16'h5A5A, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("sat.a_stall", a_stall, 15);
      checkOutput("sat.b_stall", b_stall, 20);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);

      // Randomised traffic against the models.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
      end
      checkAll();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
